// File: rtl/exhaustive_compare_engine.sv
// Sweeps every IN_W-bit vector into two implementations, compares their outputs on the last
// hold cycle and reports mismatch count, first failing vector and pass/fail.
// Optional STOP_ON_FIRST_ERR_EN: end the sweep at the first mismatching compare.
module exhaustive_compare_engine #(
  parameter int unsigned IN_W      = 3,
  parameter int unsigned OUT_W     = 1,
  parameter int unsigned HOLD      = 20,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OUT_W-1:0]     dut0_f,
  input  logic [OUT_W-1:0]     dut1_f,
  output logic [IN_W-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 match,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 first_err_valid,
  output logic [IN_W-1:0]      first_err_vec
);

  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [IN_W-1:0]      stim_q, stim_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 fev_q, fev_d;
  logic [IN_W-1:0]      fe_vec_q, fe_vec_d;
  logic                 pass_q, pass_d;
  logic                 match_q;

  logic cmp_cycle, mismatch, last_vec, stop_err, sweep_end, launch;

  assign cmp_cycle = (state_q == StRun) && (hold_cnt_q == HoldLast);
  assign mismatch  = cmp_cycle && (dut0_f != dut1_f);
  assign last_vec  = (stim_q == '1);
  // start is honoured from IDLE and DONE only; a start mid-sweep is dropped
  assign launch    = start && (state_q != StRun);

`ifdef STOP_ON_FIRST_ERR_EN
  assign stop_err = mismatch;
`else
  assign stop_err = 1'b0;
`endif

  assign sweep_end = cmp_cycle && (last_vec || stop_err);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (sweep_end) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
    stim            = stim_q;
    pass            = pass_q;
    match           = match_q;
    err_cnt         = err_cnt_q;
    first_err_valid = fev_q;
    first_err_vec   = fe_vec_q;
  end

  // Sweep datapath next-state
  always_comb begin
    stim_d     = stim_q;
    hold_cnt_d = hold_cnt_q;
    err_cnt_d  = err_cnt_q;
    fev_d      = fev_q;
    fe_vec_d   = fe_vec_q;
    pass_d     = pass_q;
    if (launch) begin
      stim_d     = '0;
      hold_cnt_d = '0;
      err_cnt_d  = '0;
      fev_d      = 1'b0;
      fe_vec_d   = '0;
      pass_d     = 1'b0;
    end else if (state_q == StRun) begin
      if (cmp_cycle) begin
        if (mismatch) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          if (!fev_q) begin
            fev_d    = 1'b1;
            fe_vec_d = stim_q;
          end
        end
        if (sweep_end) begin
          // the final compare counts towards the verdict
          pass_d = (err_cnt_q == '0) && !mismatch;
        end else begin
          stim_d     = stim_q + IN_W'(1);
          hold_cnt_d = '0;
        end
      end else begin
        hold_cnt_d = hold_cnt_q + HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stim_q     <= '0;
      hold_cnt_q <= '0;
      err_cnt_q  <= '0;
      fev_q      <= 1'b0;
      fe_vec_q   <= '0;
      pass_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      stim_q     <= stim_d;
      hold_cnt_q <= hold_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fev_q      <= fev_d;
      fe_vec_q   <= fe_vec_d;
      pass_q     <= pass_d;
      match_q    <= (dut0_f == dut1_f);
    end
  end

endmodule
